// File: rtl/cmem_load_ctrl_if.sv
// Handshake/control bundle between the weight-decomposition stage, cmem_load_ctrl and the CMEM.
// pad_count is present only when CMEM_CTRL_STATS_EN is defined.
interface cmem_load_ctrl_if #(
    parameter int SIZE  = 8,
    parameter int COL_W = $clog2(SIZE)
);
    logic             start_load;
    logic [2:0]       cw_in;
    logic             cw_in_valid;
    logic             cw_in_last;
    logic             cw_in_ready;
    logic             preload_req;
    logic [2:0]       mem_cw;
    logic             mem_cw_valid;
    logic             mem_load_done;
    logic             mem_preload_en;
    logic             preload_done;
    logic             busy;
`ifdef CMEM_CTRL_STATS_EN
    logic [COL_W+1:0] pad_count;

    modport master (
        output start_load, cw_in, cw_in_valid, cw_in_last, preload_req,
        input  cw_in_ready, mem_cw, mem_cw_valid, mem_load_done, mem_preload_en,
               preload_done, busy, pad_count
    );

    modport slave (
        input  start_load, cw_in, cw_in_valid, cw_in_last, preload_req,
        output cw_in_ready, mem_cw, mem_cw_valid, mem_load_done, mem_preload_en,
               preload_done, busy, pad_count
    );
`else
    modport master (
        output start_load, cw_in, cw_in_valid, cw_in_last, preload_req,
        input  cw_in_ready, mem_cw, mem_cw_valid, mem_load_done, mem_preload_en,
               preload_done, busy
    );

    modport slave (
        input  start_load, cw_in, cw_in_valid, cw_in_last, preload_req,
        output cw_in_ready, mem_cw, mem_cw_valid, mem_load_done, mem_preload_en,
               preload_done, busy
    );
`endif
endinterface

// File: rtl/cmem_load_ctrl.sv
// Load/preload sequencer for the compensation-weight memory: pads short columns to 3 slots
// and times the preload burst. Optional pad statistics under CMEM_CTRL_STATS_EN.
module cmem_load_ctrl #(
    parameter int SIZE      = 8,
    parameter int CMEM_SIZE = SIZE * 3,
    parameter int COL_W     = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    cmem_load_ctrl_if.slave  bus
);
    localparam int              COLS     = CMEM_SIZE / 3;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        READY,
        PRELOAD
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [1:0]       slot;
    logic [1:0]       pcnt;
    logic             pending;
    logic             hs;

    assign hs       = bus.cw_in_valid && bus.cw_in_ready;
    assign bus.busy = (state != IDLE) && (state != READY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            col                <= '0;
            slot               <= '0;
            pcnt               <= '0;
            pending            <= 1'b0;
            bus.cw_in_ready    <= 1'b0;
            bus.mem_cw         <= '0;
            bus.mem_cw_valid   <= 1'b0;
            bus.mem_load_done  <= 1'b0;
            bus.mem_preload_en <= 1'b0;
            bus.preload_done   <= 1'b0;
`ifdef CMEM_CTRL_STATS_EN
            bus.pad_count      <= '0;
`endif
        end else begin
            bus.mem_cw_valid <= 1'b0;
            bus.preload_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_load) begin
                        state           <= LOAD;
                        col             <= '0;
                        slot            <= '0;
                        bus.cw_in_ready <= 1'b1;
`ifdef CMEM_CTRL_STATS_EN
                        bus.pad_count   <= '0;
`endif
                    end
                end

                LOAD: begin
                    if (bus.preload_req) pending <= 1'b1;
                    if (hs) begin
                        bus.mem_cw       <= bus.cw_in;
                        bus.mem_cw_valid <= 1'b1;
                        // slot 2 closes the column regardless of cw_in_last; earlier lasts owe zero fills
                        if (slot == 2'd2) begin
                            slot <= '0;
                            col  <= col + 1'b1;
                            if (col == LAST_COL) begin
                                state           <= READY;
                                bus.cw_in_ready <= 1'b0;
                            end
                        end else if (bus.cw_in_last) begin
                            state           <= PAD;
                            slot            <= slot + 2'd1;
                            bus.cw_in_ready <= 1'b0;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end

                PAD: begin
                    if (bus.preload_req) pending <= 1'b1;
                    bus.mem_cw       <= '0;
                    bus.mem_cw_valid <= 1'b1;
`ifdef CMEM_CTRL_STATS_EN
                    bus.pad_count    <= bus.pad_count + 1'b1;
`endif
                    if (slot == 2'd2) begin
                        slot <= '0;
                        col  <= col + 1'b1;
                        if (col == LAST_COL) begin
                            state <= READY;
                        end else begin
                            state           <= LOAD;
                            bus.cw_in_ready <= 1'b1;
                        end
                    end else begin
                        slot <= slot + 2'd1;
                    end
                end

                READY: begin
                    // A preload request outranks a simultaneous start_load, which is dropped
                    if (bus.preload_req || pending) begin
                        state              <= PRELOAD;
                        pcnt               <= '0;
                        pending            <= 1'b0;
                        bus.mem_preload_en <= 1'b1;
                        bus.mem_load_done  <= 1'b1;
                    end else if (bus.start_load) begin
                        state             <= LOAD;
                        col               <= '0;
                        slot              <= '0;
                        bus.cw_in_ready   <= 1'b1;
                        bus.mem_load_done <= 1'b0;
`ifdef CMEM_CTRL_STATS_EN
                        bus.pad_count     <= '0;
`endif
                    end else begin
                        bus.mem_load_done <= 1'b1;
                    end
                end

                PRELOAD: begin
                    pcnt <= pcnt + 2'd1;
                    if (pcnt == 2'd2) bus.preload_done <= 1'b1;
                    if (pcnt == 2'd3) begin
                        state              <= READY;
                        bus.mem_preload_en <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmem_load_ctrl.sv
// Randomized + directed bench for cmem_load_ctrl against a slot-counting reference model.
module tb_cmem_load_ctrl;
    localparam int SIZE = 8;
    localparam int CMEM = SIZE * 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmem_load_ctrl_if #(.SIZE(SIZE)) bus ();

    cmem_load_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: counts memory slots claimed in the current load, zeros still owed,
    // and remaining preload-enable cycles.
    bit       m_fill, m_complete, m_pend, m_wv, m_done;
    int       m_slots, m_owed, m_burst, m_pads;
    bit [2:0] m_wd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fill = 0; m_complete = 0; m_pend = 0; m_wv = 0; m_done = 0;
            m_slots = 0; m_owed = 0; m_burst = 0; m_pads = 0; m_wd = 0;
        end else begin
            m_wv = 0;
            if (m_fill) begin
                if (bus.preload_req) m_pend = 1;
                if (m_owed > 0) begin
                    m_wv = 1; m_wd = 0; m_slots++; m_owed--; m_pads++;
                end else if (bus.cw_in_valid) begin
                    m_wv = 1; m_wd = bus.cw_in; m_slots++;
                    if (bus.cw_in_last && (m_slots % 3) != 0) m_owed = 3 - (m_slots % 3);
                end
                if (m_slots == CMEM && m_owed == 0) begin
                    m_fill = 0; m_complete = 1;
                end
            end else if (m_burst > 0) begin
                m_burst--;
            end else if (m_complete) begin
                if (bus.preload_req || m_pend) begin
                    m_burst = 4; m_pend = 0; m_done = 1;
                end else if (bus.start_load) begin
                    m_fill = 1; m_slots = 0; m_done = 0; m_complete = 0; m_pads = 0;
                end else begin
                    m_done = 1;
                end
            end else if (bus.start_load) begin
                m_fill = 1; m_slots = 0; m_pads = 0;
            end
        end
    end

    bit            chk_en = 0;
    logic [2:0]    wlog[$];
    int            pen_cnt, pdone_cnt;

    always @(negedge clk) begin
        if (bus.mem_cw_valid) wlog.push_back(bus.mem_cw);
        if (bus.mem_preload_en) pen_cnt++;
        if (bus.preload_done) pdone_cnt++;
        if (chk_en) begin
            chk("cw_in_ready", bus.cw_in_ready, int'(m_fill && m_owed == 0));
            chk("mem_cw_valid", bus.mem_cw_valid, m_wv);
            if (m_wv) chk("mem_cw", bus.mem_cw, m_wd);
            chk("mem_load_done", bus.mem_load_done, m_done);
            chk("mem_preload_en", bus.mem_preload_en, int'(m_burst > 0));
            chk("preload_done", bus.preload_done, int'(m_burst == 1));
            chk("busy", bus.busy, int'(m_fill || m_burst > 0));
`ifdef CMEM_CTRL_STATS_EN
            chk("pad_count", bus.pad_count, m_pads);
`endif
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic pulse_start();
        bus.start_load = 1'b1; cyc(1); bus.start_load = 1'b0;
    endtask

    task automatic pulse_preload();
        bus.preload_req = 1'b1; cyc(1); bus.preload_req = 1'b0;
    endtask

    task automatic send(input logic [2:0] v, input bit last);
        int n = 0;
        bus.cw_in = v; bus.cw_in_valid = 1'b1; bus.cw_in_last = last;
        while (!bus.cw_in_ready && n < 50) begin cyc(1); n++; end
        chk("hs_wait_bound", int'(n < 50), 1);
        cyc(1);
        bus.cw_in_valid = 1'b0; bus.cw_in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.mem_load_done && n < 60) begin cyc(1); n++; end
        chk("load_done_bound", int'(n < 60), 1);
    endtask

    initial begin
        logic [2:0] c1v;
        bus.start_load = 0; bus.cw_in = 0; bus.cw_in_valid = 0;
        bus.cw_in_last = 0; bus.preload_req = 0;
        #2;
        chk("rst_ready", bus.cw_in_ready, 0);
        chk("rst_mem_cw", bus.mem_cw, 0);
        chk("rst_valid", bus.mem_cw_valid, 0);
        chk("rst_done", bus.mem_load_done, 0);
        chk("rst_pen", bus.mem_preload_en, 0);
`ifdef CMEM_CTRL_STATS_EN
        chk("rst_pad_count", bus.pad_count, 0);
`endif
        do_reset();
        chk_en = 1;

        // 24 back-to-back weights, no padding
        wlog.delete();
        pulse_start();
        for (int i = 0; i < CMEM; i++) send(3'((i % 7) + 1), 1'b0);
        chk("t1_ready_low", bus.cw_in_ready, 0);
        chk("t1_last_valid", bus.mem_cw_valid, 1);
        chk("t1_done_not_yet", bus.mem_load_done, 0);
        cyc(1);
        chk("t1_done_rise", bus.mem_load_done, 1);
        chk("t1_nwrites", wlog.size(), 24);
        for (int i = 0; i < CMEM && i < wlog.size(); i++)
            chk("t1_wdata", wlog[i], (i % 7) + 1);

        // Short column 0, pending preload collapse, repeated bursts
        do_reset();
        wlog.delete(); pen_cnt = 0; pdone_cnt = 0;
        pulse_start();
        send(3'd5, 1'b1);
        chk("t2_pad_ready0", bus.cw_in_ready, 0);
        bus.preload_req = 1'b1; cyc(1); bus.preload_req = 1'b0;
        chk("t2_pad_ready1", bus.cw_in_ready, 0);
        cyc(1);
        chk("t2_pad_ready2", bus.cw_in_ready, 1);
        c1v = 3'($urandom_range(1, 7));
        for (int c = 1; c < SIZE; c++)
            for (int s = 0; s < 3; s++) begin
                if (c == 3 && s == 1) pulse_preload();
                send((c == 1 && s == 0) ? c1v : 3'($urandom), (c == SIZE - 1 && s == 2));
            end
        wait_done();
        cyc(8);
        chk("t2_w0", wlog.size() > 0 ? int'(wlog[0]) : -1, 5);
        chk("t2_w1", wlog.size() > 1 ? int'(wlog[1]) : -1, 0);
        chk("t2_w2", wlog.size() > 2 ? int'(wlog[2]) : -1, 0);
        chk("t2_w3", wlog.size() > 3 ? int'(wlog[3]) : -1, c1v);
        chk("t2_nwrites", wlog.size(), 24);
`ifdef CMEM_CTRL_STATS_EN
        chk("t2_pad_count", bus.pad_count, 2);
`endif
        chk("t2_pending_burst_len", pen_cnt, 4);
        chk("t2_pending_burst_done", pdone_cnt, 1);
        for (int r = 0; r < 2; r++) begin
            pen_cnt = 0; pdone_cnt = 0;
            pulse_preload();
            cyc(8);
            chk("t2_burst_len", pen_cnt, 4);
            chk("t2_burst_done", pdone_cnt, 1);
            chk("t2_burst_keeps_done", bus.mem_load_done, 1);
        end

        // Asynchronous reset mid-load
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) send(3'($urandom), 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("t3_ready", bus.cw_in_ready, 0);
        chk("t3_valid", bus.mem_cw_valid, 0);
        chk("t3_mem_cw", bus.mem_cw, 0);
        chk("t3_busy", bus.busy, 0);
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk("t3_ready_after", bus.cw_in_ready, 0);

        // Simultaneous start_load + preload_req in READY
        pulse_start();
        for (int i = 0; i < CMEM; i++) send(3'($urandom), 1'b0);
        cyc(2);
        bus.start_load = 1'b1; bus.preload_req = 1'b1;
        cyc(1);
        bus.start_load = 1'b0; bus.preload_req = 1'b0;
        chk("t4_pen", bus.mem_preload_en, 1);
        chk("t4_done_kept", bus.mem_load_done, 1);
        cyc(6);
        pulse_start();
        chk("t4_done_drop", bus.mem_load_done, 0);
        chk("t4_ready_open", bus.cw_in_ready, 1);

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            bus.start_load  = ($urandom_range(0, 19) == 0);
            bus.preload_req = ($urandom_range(0, 9) == 0);
            bus.cw_in_valid = ($urandom_range(0, 3) != 0);
            bus.cw_in_last  = ($urandom_range(0, 2) == 0);
            bus.cw_in       = 3'($urandom);
            if ($urandom_range(0, 599) == 0) rst = 1'b0;
            cyc(1);
            rst = 1'b1;
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmem_load_ctrl.md
Name: cmem_load_ctrl

Overview:
- Sequencer in front of the compensation-weight memory (CMEM_SIZE = SIZE*3 entries of 3 bits; 3 slots per column, SIZE columns).
- Accepts a valid/ready stream of 3-bit compensation weights from the weight-decomposition stage and pads short columns with zeros, so every column occupies exactly 3 slots.
- Drives the memory's write-valid, load-done and preload-enable controls, and times the 3-step preload burst into the systolic array.
- Queues preload requests that arrive while a load is in progress.

Parameters:
- SIZE, 8, systolic array dimension (number of columns).
- CMEM_SIZE, SIZE*3, total memory entries.
- COL_W, $clog2(SIZE), column counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_load  input  1  pulse; begin a new load.
- cw_in  input  3  compensation weight.
- cw_in_valid  input  1  cw_in valid.
- cw_in_last  input  1  qualifies cw_in; last weight of current column.
- cw_in_ready  output  1  controller accepts cw_in.
- preload_req  input  1  pulse; request a preload burst.
- mem_cw  output  3  weight to memory.
- mem_cw_valid  output  1  memory write strobe.
- mem_load_done  output  1  memory fully loaded.
- mem_preload_en  output  1  memory preload enable.
- preload_done  output  1  one-cycle pulse, burst finished.
- busy  output  1  state is not IDLE and not READY.
- pad_count  output  COL_W+2  zero slots written in the last load (present only with CMEM_CTRL_STATS_EN).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; counters cleared; pending cleared.
- Output reset values: cw_in_ready, mem_cw, mem_cw_valid, mem_load_done, mem_preload_en, preload_done and pad_count all 0.
- States: IDLE, LOAD, PAD, READY, PRELOAD.
- IDLE: start_load -> LOAD; col=0, slot=0.
- LOAD:
  - cw_in_ready=1.
  - A handshake (valid&ready) registers mem_cw<=cw_in and mem_cw_valid<=1 on the next cycle, i.e. 1-cycle latency.
  - If slot==2, or cw_in_last: close the column, slot<=0, col<=col+1.
  - If cw_in_last and slot<2: go to PAD instead, with the remaining 2-slot zero writes outstanding.
  - Otherwise slot<=slot+1.
  - cw_in_last on slot 2 is legal and needs no padding.
- PAD:
  - cw_in_ready=0.
  - Emits one mem_cw=0 write per cycle until slot wraps to 0.
  - Then returns to LOAD, or goes to READY if the last column has closed.
- Final column close (col==SIZE-1 closing) -> READY.
  - cw_in_ready drops in the same cycle as the final handshake is registered; no further input is accepted.
  - mem_load_done rises the cycle after the final mem_cw_valid cycle and stays high in READY/PRELOAD.
  - Exactly CMEM_SIZE writes occur per load, so the memory index wraps to 0.
- READY:
  - preload_req, or a pending request -> PRELOAD, pcnt=0.
  - start_load -> clear mem_load_done, go to LOAD.
  - If both arrive in the same cycle, preload wins; start_load is dropped.
- PRELOAD:
  - mem_preload_en=1 for exactly 4 cycles (pcnt 0..3): 3 output updates plus 1 cycle for the memory index to reach its stop value.
  - preload_done=1 in the pcnt==3 cycle, then READY; mem_preload_en=0 in READY, which rewinds the memory index.
  - Bursts are repeatable from READY without reloading.
- preload_req in LOAD/PAD: sets pending (a single flag; multiple requests collapse to one). Serviced on the first READY cycle.
- preload_req in IDLE: ignored.
- start_load in LOAD/PAD/PRELOAD: ignored.
- Reset mid-operation: immediate return to reset values. The partial load is discarded; start_load is required again.

Optional Feature:
- CMEM_CTRL_STATS_EN defined:
  - pad_count port exists.
  - Cleared on start_load; +1 per PAD write.
  - Holds its value through READY/PRELOAD.
- Not defined: no port, no counter logic; all other behaviour identical.

Test Plan:
- start_load, then 24 back-to-back weights (values 1..7 cycling), no cw_in_last -> 24 mem_cw_valid cycles with matching data, each 1 cycle after its handshake. cw_in_ready low after the 24th. mem_load_done rises the cycle after the last write.
- Column 0: one weight 5 with cw_in_last -> writes 5,0,0. cw_in_ready low for 2 cycles. pad_count=2 at READY (with STATS_EN). Column 1 data starts at write 4.
- After load, preload_req pulse -> mem_preload_en high exactly 4 cycles, preload_done in the 4th, back to READY. A second preload_req repeats the identical 4-cycle burst.
- preload_req pulsed twice during LOAD -> exactly one PRELOAD, starting the cycle after READY entry.
- rst=0 after 10 accepted weights -> all outputs 0 immediately. After release, cw_in_ready stays 0 until start_load.
- In READY, assert start_load and preload_req in the same cycle -> PRELOAD taken, mem_load_done stays 1. A later start_load alone drops mem_load_done and reopens LOAD.
